// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute stage: widths, aluop/funct3 encodings,
// multiply/divide FSM states and the operand-signedness helpers.
package ex_muldiv_pkg;

    localparam int XLEN = 32;
    localparam int AOW  = 4;
    localparam int FW   = 3;

    localparam logic RstEnable = 1'b1;

    localparam logic [AOW-1:0] ALUOP_NOP    = 4'd0;
    localparam logic [AOW-1:0] ALUOP_ARITH  = 4'd1;
    localparam logic [AOW-1:0] ALUOP_SUB    = 4'd2;
    localparam logic [AOW-1:0] ALUOP_SRA    = 4'd3;
    localparam logic [AOW-1:0] ALUOP_MULDIV = 4'd4;

    localparam logic [FW-1:0] F3_ADD  = 3'd0;
    localparam logic [FW-1:0] F3_SLL  = 3'd1;
    localparam logic [FW-1:0] F3_SLT  = 3'd2;
    localparam logic [FW-1:0] F3_SLTU = 3'd3;
    localparam logic [FW-1:0] F3_XOR  = 3'd4;
    localparam logic [FW-1:0] F3_SRL  = 3'd5;
    localparam logic [FW-1:0] F3_OR   = 3'd6;
    localparam logic [FW-1:0] F3_AND  = 3'd7;

    localparam logic [FW-1:0] F3_MUL    = 3'd0;
    localparam logic [FW-1:0] F3_MULH   = 3'd1;
    localparam logic [FW-1:0] F3_MULHSU = 3'd2;
    localparam logic [FW-1:0] F3_MULHU  = 3'd3;
    localparam logic [FW-1:0] F3_DIV    = 3'd4;
    localparam logic [FW-1:0] F3_DIVU   = 3'd5;
    localparam logic [FW-1:0] F3_REM    = 3'd6;
    localparam logic [FW-1:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic f3_a_signed(input logic [FW-1:0] f3);
        case (f3)
            F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic f3_b_signed(input logic [FW-1:0] f3);
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M unit: 32-cycle shift-add multiplier and restoring divider
// working on operand magnitudes, with sign fix-up applied in DONE.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [FW-1:0]   i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output md_state_t       o_state
);

    // Handshake: i_start is a level sampled only in IDLE; o_busy is high from
    // the start cycle until the result exists; o_done is high for exactly one
    // cycle with o_result valid; i_funct3/i_a/i_b must hold while o_busy=1.

    md_state_t         r_state;
    logic [5:0]        r_count;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [FW-1:0]     r_funct3;
    logic              r_neg_res;
    logic              r_neg_rem;

    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_neg_a = f3_a_signed(i_funct3) & i_a[XLEN-1];
    assign w_neg_b = f3_b_signed(i_funct3) & i_b[XLEN-1];
    assign w_mag_a = w_neg_a ? -i_a : i_a;
    assign w_mag_b = w_neg_b ? -i_b : i_b;

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});

    // Divide: r_acc = {partial remainder, dividend bits / quotient bits}.
    assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[XLEN]
                       ? {r_acc[2*XLEN-2:0], 1'b0}
                       : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state   <= ST_IDLE;
            r_count   <= 6'd0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_funct3  <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_funct3 <= i_funct3;
                        r_count  <= 6'd0;
                        if (i_funct3[2]) begin
                            if (i_b == '0) begin
                                r_acc     <= {i_a, {XLEN{1'b1}}};
                                r_opb     <= '0;
                                r_neg_res <= 1'b0;
                                r_neg_rem <= 1'b0;
                                r_state   <= ST_DONE;
                            end else begin
                                r_acc     <= {{XLEN{1'b0}}, w_mag_a};
                                r_opb     <= w_mag_b;
                                r_neg_res <= w_neg_a ^ w_neg_b;
                                r_neg_rem <= w_neg_a;
                                r_state   <= ST_DIV;
                            end
                        end else begin
                            r_acc     <= {{XLEN{1'b0}}, w_mag_b};
                            r_opb     <= w_mag_a;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= 1'b0;
                            r_state   <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc   <= {w_mul_sum, r_acc[XLEN-1:1]};
                    r_count <= r_count + 6'd1;
                    if (r_count == 6'd31) r_state <= ST_DONE;
                end
                ST_DIV: begin
                    r_acc   <= w_div_next;
                    r_count <= r_count + 6'd1;
                    if (r_count == 6'd31) r_state <= ST_DONE;
                end
                default: begin
                    r_count <= 6'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        o_result = '0;
        case (r_funct3)
            F3_MUL:                        o_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               o_result = w_quot;
            default:                       o_result = w_rem;
        endcase
    end

    assign o_busy  = ((r_state == ST_IDLE) && i_start)
                   || (r_state == ST_MUL) || (r_state == ST_DIV);
    assign o_done  = (r_state == ST_DONE);
    assign o_state = r_state;

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle RV32I ALU plus the iterative RV32M unit, with
// stall generation and write-back gating toward the EX/MEM register.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AOW-1:0]  ex_aluop,
    input  logic [FW-1:0]   ex_alufun,
    input  logic [XLEN-1:0] ex_reg1,
    input  logic [XLEN-1:0] ex_reg2,
    input  logic [4:0]      ex_wd,
    input  logic            ex_wreg,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stallreq_o
);

    logic            w_md_start;
    logic            w_md_busy;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;
    md_state_t       w_unused_md_state;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic            w_alu_wr;

    assign w_md_start = (ex_aluop == ALUOP_MULDIV) && (rst != RstEnable);
    assign w_shamt    = ex_reg2[4:0];

    ex_muldiv_unit u_unit (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_funct3 (ex_alufun),
        .i_a      (ex_reg1),
        .i_b      (ex_reg2),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result),
        .o_state  (w_unused_md_state)
    );

    // Illegal aluop/funct3 pairings fall through as NOP: no data, no write.
    always_comb begin
        w_alu_res = '0;
        w_alu_wr  = 1'b0;
        case (ex_aluop)
            ALUOP_ARITH: begin
                w_alu_wr = 1'b1;
                case (ex_alufun)
                    F3_ADD:  w_alu_res = ex_reg1 + ex_reg2;
                    F3_SLL:  w_alu_res = ex_reg1 << w_shamt;
                    F3_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(ex_reg1) < $signed(ex_reg2)};
                    F3_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, ex_reg1 < ex_reg2};
                    F3_XOR:  w_alu_res = ex_reg1 ^ ex_reg2;
                    F3_SRL:  w_alu_res = ex_reg1 >> w_shamt;
                    F3_OR:   w_alu_res = ex_reg1 | ex_reg2;
                    default: w_alu_res = ex_reg1 & ex_reg2;
                endcase
            end
            ALUOP_SUB: begin
                if (ex_alufun == F3_ADD) begin
                    w_alu_wr  = 1'b1;
                    w_alu_res = ex_reg1 - ex_reg2;
                end
            end
            ALUOP_SRA: begin
                if (ex_alufun == F3_SRL) begin
                    w_alu_wr  = 1'b1;
                    w_alu_res = $unsigned($signed(ex_reg1) >>> w_shamt);
                end
            end
            default: begin
                w_alu_res = '0;
                w_alu_wr  = 1'b0;
            end
        endcase
    end

    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (rst != RstEnable) begin
            wd_o = ex_wd;
            if (w_md_done) begin
                wreg_o  = ex_wreg;
                wdata_o = w_md_result;
            end else if (w_md_busy) begin
                stallreq_o = 1'b1;
            end else begin
                wreg_o  = ex_wreg & w_alu_wr;
                wdata_o = w_alu_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus random bench for ex_muldiv: an expected-result queue is filled
// when an instruction is driven and drained when the stage writes back.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [AOW-1:0]  ex_aluop;
    logic [FW-1:0]   ex_alufun;
    logic [XLEN-1:0] ex_reg1;
    logic [XLEN-1:0] ex_reg2;
    logic [4:0]      ex_wd;
    logic            ex_wreg;
    logic [4:0]      wd_o;
    logic            wreg_o;
    logic [XLEN-1:0] wdata_o;
    logic            stallreq_o;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [XLEN-1:0] exp_q[$];

    ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .ex_aluop   (ex_aluop),
        .ex_alufun  (ex_alufun),
        .ex_reg1    (ex_reg1),
        .ex_reg2    (ex_reg2),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference RV32M results computed with wide native arithmetic.
    function automatic logic [XLEN-1:0] md_model(input logic [FW-1:0] f3,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic alu_step(input string tag, input logic [AOW-1:0] op, input logic [FW-1:0] f3,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [4:0] wd, input logic wr,
                            input logic [XLEN-1:0] exp_data, input logic exp_wr);
        @(negedge clk);
        ex_aluop  = op;
        ex_alufun = f3;
        ex_reg1   = a;
        ex_reg2   = b;
        ex_wd     = wd;
        ex_wreg   = wr;
        exp_q.push_back(exp_data);
        #1;
        check({tag, ":wdata"}, wdata_o, exp_q.pop_front());
        check({tag, ":wreg"}, 32'(wreg_o), 32'(exp_wr));
        check({tag, ":wd"}, 32'(wd_o), 32'(wd));
        check({tag, ":stall"}, 32'(stallreq_o), 32'd0);
    endtask

    task automatic md_step(input string tag, input logic [FW-1:0] f3,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit b2b);
        int n;
        int bad;
        int exp_n;
        if (!b2b) @(negedge clk);
        ex_aluop  = ALUOP_MULDIV;
        ex_alufun = f3;
        ex_reg1   = a;
        ex_reg2   = b;
        ex_wd     = 5'd10;
        ex_wreg   = 1'b1;
        exp_q.push_back(md_model(f3, a, b));
        exp_n = (f3[2] && b == 0) ? 1 : 33;
        if (b2b) @(negedge clk);
        #1;
        n   = 0;
        bad = 0;
        while (stallreq_o === 1'b1 && n < 40) begin
            n++;
            if (wreg_o !== 1'b0 || wdata_o !== '0) bad++;
            @(negedge clk);
            #1;
        end
        check({tag, ":stall_cycles"}, n, exp_n);
        check({tag, ":gated_during_stall"}, bad, 0);
        check({tag, ":wreg"}, 32'(wreg_o), 32'd1);
        check({tag, ":wd"}, 32'(wd_o), 32'd10);
        check({tag, ":result"}, wdata_o, exp_q.pop_front());
        ex_aluop = ALUOP_NOP;
    endtask

    initial begin
        logic [FW-1:0]   rf3;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;

        rst       = 1'b1;
        ex_aluop  = ALUOP_ARITH;
        ex_alufun = F3_ADD;
        ex_reg1   = 32'd5;
        ex_reg2   = 32'd7;
        ex_wd     = 5'd3;
        ex_wreg   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset:wdata", wdata_o, 32'd0);
        check("reset:wreg", 32'(wreg_o), 32'd0);
        check("reset:wd", 32'(wd_o), 32'd0);
        check("reset:stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        alu_step("add",   ALUOP_ARITH, F3_ADD,  32'd5,        32'd7,  5'd3, 1'b1, 32'd12,        1'b1);
        alu_step("sub",   ALUOP_SUB,   F3_ADD,  32'd3,        32'd5,  5'd4, 1'b1, 32'hFFFF_FFFE, 1'b1);
        alu_step("sra",   ALUOP_SRA,   F3_SRL,  32'h8000_0000, 32'd4, 5'd5, 1'b1, 32'hF800_0000, 1'b1);
        alu_step("sltu",  ALUOP_ARITH, F3_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 32'd0,         1'b1);
        alu_step("slt",   ALUOP_ARITH, F3_SLT,  32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1, 32'd1,         1'b1);
        alu_step("sll",   ALUOP_ARITH, F3_SLL,  32'd1,        32'd33, 5'd8, 1'b1, 32'd2,         1'b1);
        alu_step("srl",   ALUOP_ARITH, F3_SRL,  32'h8000_0000, 32'd31, 5'd9, 1'b1, 32'd1,        1'b1);
        alu_step("xor",   ALUOP_ARITH, F3_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 1'b1, 32'hFF00_EDCB, 1'b1);
        alu_step("or",    ALUOP_ARITH, F3_OR,   32'hA000_0001, 32'h0500_0010, 5'd2, 1'b1, 32'hA500_0011, 1'b1);
        alu_step("and",   ALUOP_ARITH, F3_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd2, 1'b1, 32'h0F00_0F00, 1'b1);
        alu_step("nop",   ALUOP_NOP,   F3_ADD,  32'd5,        32'd7,  5'd3, 1'b1, 32'd0,         1'b0);
        alu_step("badop", 4'd7,        F3_ADD,  32'd5,        32'd7,  5'd3, 1'b1, 32'd0,         1'b0);
        alu_step("badsub", ALUOP_SUB,  F3_SLL,  32'd5,        32'd7,  5'd3, 1'b1, 32'd0,         1'b0);

        md_step("mulh",     F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        md_step("mulhu",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        md_step("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         1'b0);
        md_step("mul",      F3_MUL,    32'h0001_2345, 32'hFFFF_FFFD, 1'b0);
        md_step("div_neg",  F3_DIV,    32'hFFFF_FFF9, 32'd2,         1'b0);
        md_step("rem_neg",  F3_REM,    32'hFFFF_FFF9, 32'd2,         1'b0);
        md_step("div_ovf",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_step("rem_ovf",  F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_step("divu_z",   F3_DIVU,   32'd9,         32'd0,         1'b0);
        md_step("remu_z",   F3_REMU,   32'd9,         32'd0,         1'b0);
        md_step("rem_negz", F3_REM,    32'hFFFF_FFFB, 32'd0,         1'b0);
        md_step("divu",     F3_DIVU,   32'hFFFF_FFF0, 32'd7,         1'b0);
        md_step("b2b_mulh", F3_MULH,   32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rf3 = FW'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            md_step($sformatf("rand%0d", i), rf3, ra, rb, 1'b0);
        end

        @(negedge clk);
        ex_aluop  = ALUOP_MULDIV;
        ex_alufun = F3_MUL;
        ex_reg1   = 32'd3;
        ex_reg2   = 32'd4;
        repeat (10) @(negedge clk);
        #1;
        check("abort:busy_before", 32'(stallreq_o), 32'd1);
        rst = 1'b1;
        #1;
        check("abort:stall_in_rst", 32'(stallreq_o), 32'd0);
        check("abort:wreg_in_rst", 32'(wreg_o), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        ex_aluop = ALUOP_NOP;
        #1;
        check("abort:stall_after", 32'(stallreq_o), 32'd0);
        check("abort:wreg_after", 32'(wreg_o), 32'd0);
        check("abort:state_idle", 32'(dut.u_unit.o_state), 32'(ST_IDLE));
        alu_step("abort:add", ALUOP_ARITH, F3_ADD, 32'd100, 32'd23, 5'd12, 1'b1, 32'd123, 1'b1);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
